// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings for the PC/fetch sequencer: next-PC select codes, FSM states
// and the default reset vector.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_JR  = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle between the core datapath / instruction memory and the
// PC sequencer. The sequencer uses the slave view, its environment the master view.
interface pc_fetch_ctrl_if #(
    parameter int AW = 32
);
    logic [1:0]    pc_src;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic [25:0]   jump_index;
    logic [AW-1:0] reg_target;
    logic          stall;
    logic          halt;
    logic          imem_ack;

    logic [AW-1:0] pc_out;
    logic [AW-1:0] pc_plus4;
    logic          imem_req;
    logic          instr_valid;
    logic          halted;
    logic          misalign_err;

    modport slave (
        input  pc_src, branch_taken, branch_target, jump_index, reg_target,
               stall, halt, imem_ack,
        output pc_out, pc_plus4, imem_req, instr_valid, halted, misalign_err
    );

    modport master (
        output pc_src, branch_taken, branch_target, jump_index, reg_target,
               stall, halt, imem_ack,
        input  pc_out, pc_plus4, imem_req, instr_valid, halted, misalign_err
    );
endinterface

// File: rtl/pc_fetch_ctrl_pc_next_mux.sv
// Combinational next-PC selection: sequential, conditional branch, j/jal
// pseudo-direct target, or jr register target.
module pc_next_mux
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] pc,
    input  logic [1:0]    pc_src,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic [25:0]   jump_index,
    input  logic [AW-1:0] reg_target,
    output logic [AW-1:0] pc_plus4,
    output logic [AW-1:0] next_pc
);

    // Wraps naturally at 2^AW; there is deliberately no carry out.
    assign pc_plus4 = pc + {{(AW-3){1'b0}}, 3'b100};

    always_comb begin
        next_pc = pc_plus4;
        case (pcsrc_e'(pc_src))
            PCSRC_SEQ: next_pc = pc_plus4;
            PCSRC_BR:  next_pc = branch_taken ? branch_target : pc_plus4;
            PCSRC_J:   next_pc = {pc_plus4[AW-1:28], jump_index, 2'b00};
            PCSRC_JR:  next_pc = reg_target;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Architectural PC register plus BOOT/FETCH/HALT sequencer. A fetch commits when
// memory acknowledges and the pipeline is not stalled; misaligned jr targets trap.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int            AW           = 32,
    parameter logic [AW-1:0] RESET_VECTOR = AW'(DEFAULT_RESET_VECTOR)
) (
    input  logic           clk,
    input  logic           reset,
    pc_fetch_ctrl_if.slave bus
);

    fetch_state_e  state_reg;
    logic [AW-1:0] pc_reg;
    logic          imem_req_reg;
    logic          halted_reg;
    logic          misalign_err_reg;

    logic [AW-1:0] pc_plus4;
    logic [AW-1:0] next_pc;
    logic          commit;
    logic          misaligned;

    pc_next_mux #(
        .AW (AW)
    ) u_next_mux (
        .pc            (pc_reg),
        .pc_src        (bus.pc_src),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .jump_index    (bus.jump_index),
        .reg_target    (bus.reg_target),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    // A stalled acknowledge is not a commit: the same word is re-presented.
    assign commit     = (state_reg == ST_FETCH) && bus.imem_ack && !bus.stall;
    assign misaligned = (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_BOOT;
            pc_reg           <= RESET_VECTOR;
            imem_req_reg     <= 1'b0;
            halted_reg       <= 1'b0;
            misalign_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_BOOT: begin
                    state_reg    <= ST_FETCH;
                    imem_req_reg <= 1'b1;
                end
                ST_FETCH: begin
                    if (commit) begin
                        // A bad target is trapped before it reaches the PC.
                        if (misaligned) begin
                            misalign_err_reg <= 1'b1;
                            state_reg        <= ST_HALT;
                            imem_req_reg     <= 1'b0;
                            halted_reg       <= 1'b1;
                        end else begin
                            pc_reg <= next_pc;
                            if (bus.halt) begin
                                state_reg    <= ST_HALT;
                                imem_req_reg <= 1'b0;
                                halted_reg   <= 1'b1;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    imem_req_reg <= 1'b0;
                    halted_reg   <= 1'b1;
                end
                default: begin
                    state_reg    <= ST_BOOT;
                    imem_req_reg <= 1'b0;
                    halted_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_out       = pc_reg;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.imem_req     = imem_req_reg;
    assign bus.instr_valid  = commit;
    assign bus.halted       = halted_reg;
    assign bus.misalign_err = misalign_err_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and randomized check of pc_fetch_ctrl against a cycle-level reference
// model of the fetch rules (boot cycle, commit, next-PC select, halt, trap).
module tb_pc_fetch_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.AW(32)) bus ();

    pc_fetch_ctrl #(
        .AW           (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: PC value plus three phase flags.
    logic [31:0] m_pc;
    bit          m_boot, m_run, m_halt, m_err, m_known;

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] src,
                                             input bit taken, input logic [31:0] bt,
                                             input logic [25:0] ji, input logic [31:0] rt);
        logic [31:0] seq;
        seq = pc + 32'd4;
        case (src)
            2'd0:    return seq;
            2'd1:    return taken ? bt : seq;
            2'd2:    return (seq & 32'hF000_0000) | ({6'd0, ji} * 32'd4);
            default: return rt;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs before the edge, then advance model and clock.
    task automatic cycle(input bit rst, input logic [1:0] src, input bit taken,
                         input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] rt,
                         input bit stall, input bit halt, input bit ack, input string tag);
        logic [31:0] nxt;
        reset             = rst;
        bus.pc_src        = src;
        bus.branch_taken  = taken;
        bus.branch_target = bt;
        bus.jump_index    = ji;
        bus.reg_target    = rt;
        bus.stall         = stall;
        bus.halt          = halt;
        bus.imem_ack      = ack;
        #1;
        if (m_known) begin
            check({tag, "/pc_out"},  bus.pc_out,   m_pc);
            check({tag, "/pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
            check({tag, "/imem_req"}, {31'd0, bus.imem_req}, {31'd0, m_run});
            check({tag, "/instr_valid"}, {31'd0, bus.instr_valid},
                  {31'd0, m_run && ack && !stall});
            check({tag, "/halted"}, {31'd0, bus.halted}, {31'd0, m_halt});
            check({tag, "/misalign"}, {31'd0, bus.misalign_err}, {31'd0, m_err});
        end
        $display("[TB] %s rst=%0d src=%0d ack=%0d stall=%0d halt=%0d pc=%h valid=%0d",
                 tag, rst, src, ack, stall, halt, bus.pc_out, bus.instr_valid);
        if (rst) begin
            m_pc = 32'h0000_0000; m_boot = 1; m_run = 0; m_halt = 0; m_err = 0; m_known = 1;
        end else if (m_boot) begin
            m_boot = 0; m_run = 1;
        end else if (m_run && ack && !stall) begin
            nxt = ref_next(m_pc, src, taken, bt, ji, rt);
            if (nxt % 4 != 0) begin
                m_err = 1; m_run = 0; m_halt = 1;
            end else begin
                m_pc = nxt;
                if (halt) begin m_run = 0; m_halt = 1; end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic seq_step(input bit ack, input bit stall, input string tag);
        cycle(0, 2'd0, 0, 32'h0, 26'h0, 32'h0, stall, 0, ack, tag);
    endtask

    task automatic jr_step(input logic [31:0] rt, input string tag);
        cycle(0, 2'd3, 0, 32'h0, 26'h0, rt, 0, 0, 1, tag);
    endtask

    task automatic do_reset(input string tag);
        cycle(1, 2'd0, 0, 32'h0, 26'h0, 32'h0, 0, 0, 1, tag);
    endtask

    initial begin
        logic [1:0]  r_src;
        logic [31:0] r_bt, r_rt;
        logic [25:0] r_ji;
        bit          r_rst, r_taken, r_stall, r_halt, r_ack;
        m_known = 0;
        @(negedge clk);

        // 1: reset, one boot cycle, then sequential commits 0,4,8
        do_reset("t1_reset");
        seq_step(1, 0, "t1_boot");
        seq_step(1, 0, "t1_seq0");
        seq_step(1, 0, "t1_seq4");
        seq_step(1, 0, "t1_seq8");
        check("t1_pc_c", bus.pc_out, 32'h0000_000C);

        // 2: branch taken / not taken from 0x40
        jr_step(32'h0000_0040, "t2_jr40");
        cycle(0, 2'd1, 1, 32'h0000_0100, 26'h0, 32'h0, 0, 0, 1, "t2_br_taken");
        check("t2_pc_100", bus.pc_out, 32'h0000_0100);
        jr_step(32'h0000_0040, "t2_jr40b");
        cycle(0, 2'd1, 0, 32'h0000_0100, 26'h0, 32'h0, 0, 0, 1, "t2_br_not");
        check("t2_pc_44", bus.pc_out, 32'h0000_0044);

        // 3: pseudo-direct jump, then misaligned jr traps
        jr_step(32'h1000_0008, "t3_jr");
        cycle(0, 2'd2, 0, 32'h0, 26'h0000010, 32'h0, 0, 0, 1, "t3_j");
        check("t3_pc_j", bus.pc_out, 32'h1000_0040);
        jr_step(32'h0000_0202, "t3_jr_bad");
        check("t3_pc_held", bus.pc_out, 32'h1000_0040);
        check("t3_misalign", {31'd0, bus.misalign_err}, 32'd1);
        seq_step(1, 0, "t3_frozen");

        // 6a: reset out of HALT clears the sticky error
        do_reset("t6_reset_halt");
        check("t6_err_clr", {31'd0, bus.misalign_err}, 32'd0);
        check("t6_pc_rv", bus.pc_out, 32'h0000_0000);
        seq_step(1, 0, "t6_boot");

        // 4: no ack, then stalled ack, then a single commit
        seq_step(0, 0, "t4_noack0");
        seq_step(0, 0, "t4_noack1");
        seq_step(0, 0, "t4_noack2");
        seq_step(1, 1, "t4_stall0");
        seq_step(1, 1, "t4_stall1");
        check("t4_pc_hold", bus.pc_out, 32'h0000_0000);
        seq_step(1, 0, "t4_commit");
        check("t4_pc_4", bus.pc_out, 32'h0000_0004);

        // 6b: reset mid-stall
        seq_step(1, 1, "t6_stall");
        do_reset("t6_reset_stall");
        seq_step(1, 0, "t6_boot2");

        // 5: wrap at top of address space, then halt on a commit
        jr_step(32'hFFFF_FFFC, "t5_jr_top");
        seq_step(1, 0, "t5_wrap");
        check("t5_pc_wrap", bus.pc_out, 32'h0000_0000);
        cycle(0, 2'd0, 0, 32'h0, 26'h0, 32'h0, 0, 1, 1, "t5_halt");
        check("t5_halted", {31'd0, bus.halted}, 32'd1);
        check("t5_req_low", {31'd0, bus.imem_req}, 32'd0);
        seq_step(1, 0, "t5_frozen0");
        seq_step(1, 0, "t5_frozen1");
        check("t5_pc_frozen", bus.pc_out, 32'h0000_0004);

        // Randomized traffic; HALT is escaped by occasional reset.
        do_reset("rnd_reset");
        for (int i = 0; i < 400; i++) begin
            r_rst   = ($urandom_range(0, 59) == 0) || (m_halt && $urandom_range(0, 3) == 0);
            r_src   = 2'($urandom_range(0, 3));
            r_taken = 1'($urandom_range(0, 1));
            r_bt    = $urandom & 32'hFFFF_FFFC;
            r_ji    = 26'($urandom);
            r_rt    = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            r_stall = ($urandom_range(0, 4) == 0);
            r_halt  = ($urandom_range(0, 24) == 0);
            r_ack   = ($urandom_range(0, 3) != 0);
            cycle(r_rst, r_src, r_taken, r_bt, r_ji, r_rt, r_stall, r_halt, r_ack, "rnd");
        end
        seq_step(0, 0, "final");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
